// File: rtl/amp_arbiter.sv
// Round-robin arbiter sharing one amplifier path among tv, cpu and alexa.
// Grants are held for a minimum time, optionally preempted, and separated by a muted gap.
module amp_arbiter #(
  parameter int MIN_HOLD = 4,
  parameter int MAX_HOLD = 16,
  parameter int GAP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_tv,
  input  logic       req_cpu,
  input  logic       req_alexa,
  output logic       gnt_tv,
  output logic       gnt_cpu,
  output logic       gnt_alexa,
  output logic [1:0] sel,
  output logic       mute
);

  localparam int HMAX = (MAX_HOLD > MIN_HOLD) ? MAX_HOLD : MIN_HOLD;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int GW   = $clog2(GAP + 1);
  localparam logic [HW-1:0] MIN_C  = HW'(MIN_HOLD);
  localparam logic [HW-1:0] MAX_C  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HMAX_C = HW'(HMAX);
  localparam logic [GW-1:0] GAP_C  = GW'(GAP);

  typedef enum logic [1:0] {IDLE, GRANT, MUTE} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    ptr_q, ptr_d;     // 0 tv, 1 cpu, 2 alexa
  logic [1:0]    owner_q, owner_d;
  logic [2:0]    gnt_d;
  logic [1:0]    sel_d;
  logic          mute_d;

  logic [3:0] req4;
  logic [2:0] own_oh;
  logic       own_req, other_req, release_now;
  logic [1:0] c0, c1, win;
  logic       win_vld;

  assign req4      = {1'b0, req_alexa, req_cpu, req_tv};
  assign own_oh    = 3'b001 << owner_q;
  assign own_req   = req4[owner_q];
  assign other_req = |(req4[2:0] & ~own_oh);

  // Search order starts just after the last winner and wraps back to it.
  assign c0      = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
  assign c1      = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
  assign win_vld = |req4[2:0];
  assign win     = req4[c0] ? c0 : (req4[c1] ? c1 : ptr_q);

  assign release_now = ((hold_q >= MIN_C) && !own_req) ||
                       ((MAX_HOLD != 0) && (hold_q >= MAX_C) && other_req);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          owner_d = win;
          ptr_d   = win;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = MUTE;
          gap_d   = GW'(1);
          hold_d  = '0;
        end else if (hold_q < HMAX_C) begin
          hold_d = hold_q + 1'b1;
        end
      end
      MUTE: begin
        if (gap_q >= GAP_C) begin
          gap_d = '0;
          if (win_vld) begin
            state_d = GRANT;
            owner_d = win;
            ptr_d   = win;
            hold_d  = HW'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered copies decoded from the next state and owner.
  always_comb begin
    gnt_d  = '0;
    sel_d  = 2'b00;
    mute_d = 1'b1;
    if (state_d == GRANT) begin
      gnt_d  = 3'b001 << owner_d;
      sel_d  = owner_d + 2'd1;
      mute_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      gap_q     <= '0;
      ptr_q     <= 2'd2;
      owner_q   <= 2'd0;
      gnt_tv    <= 1'b0;
      gnt_cpu   <= 1'b0;
      gnt_alexa <= 1'b0;
      sel       <= 2'b00;
      mute      <= 1'b1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_tv    <= gnt_d[0];
      gnt_cpu   <= gnt_d[1];
      gnt_alexa <= gnt_d[2];
      sel       <= sel_d;
      mute      <= mute_d;
    end
  end

endmodule

// File: tb/tb_amp_arbiter.sv
// Scoreboard bench for amp_arbiter: two instances (MAX_HOLD 16 and 0) share stimulus,
// a per-instance reference model queues expected outputs, a monitor compares them.
module tb_amp_arbiter;

  localparam int MINH = 4;
  localparam int GAPN = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_tv = 1'b0, req_cpu = 1'b0, req_alexa = 1'b0;
  logic gnt_tv0, gnt_cpu0, gnt_alexa0, mute0;
  logic gnt_tv1, gnt_cpu1, gnt_alexa1, mute1;
  logic [1:0] sel0, sel1;

  amp_arbiter #(.MIN_HOLD(4), .MAX_HOLD(16), .GAP(2)) dut (
    .clk(clk), .rst(rst), .req_tv(req_tv), .req_cpu(req_cpu), .req_alexa(req_alexa),
    .gnt_tv(gnt_tv0), .gnt_cpu(gnt_cpu0), .gnt_alexa(gnt_alexa0), .sel(sel0), .mute(mute0));

  amp_arbiter #(.MIN_HOLD(4), .MAX_HOLD(0), .GAP(2)) dut_nopre (
    .clk(clk), .rst(rst), .req_tv(req_tv), .req_cpu(req_cpu), .req_alexa(req_alexa),
    .gnt_tv(gnt_tv1), .gnt_cpu(gnt_cpu1), .gnt_alexa(gnt_alexa1), .sel(sel1), .mute(mute1));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner (-1 = nobody), cycles owned so far, muted cycles left, last winner.
  int m_owner[2], m_held[2], m_gap[2], m_ptr[2];
  int m_maxh[2] = '{16, 0};
  logic [5:0] exp_q0[$];
  logic [5:0] exp_q1[$];

  function automatic logic [5:0] actual(input int i);
    if (i == 0) return {gnt_alexa0, gnt_cpu0, gnt_tv0, sel0, mute0};
    return {gnt_alexa1, gnt_cpu1, gnt_tv1, sel1, mute1};
  endfunction

  function automatic logic [5:0] model_out(input int i);
    logic [2:0] g;
    logic [1:0] s;
    if (m_owner[i] < 0) return 6'b000_00_1;
    g = 3'b000;
    g[m_owner[i]] = 1'b1;
    s = 2'(m_owner[i] + 1);
    return {g, s, 1'b0};
  endfunction

  task automatic model_reset(input int i);
    m_owner[i] = -1; m_held[i] = 0; m_gap[i] = 0; m_ptr[i] = 2;
  endtask

  task automatic model_arb(input int i, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_ptr[i] + k) % 3;
      if (r[c]) begin
        m_owner[i] = c; m_ptr[i] = c; m_held[i] = 1;
        return;
      end
    end
  endtask

  task automatic model_step(input int i, input logic [2:0] r);
    if (m_owner[i] >= 0) begin
      logic others;
      others = 1'b0;
      for (int s = 0; s < 3; s++) if (s != m_owner[i] && r[s]) others = 1'b1;
      if ((m_held[i] >= MINH && !r[m_owner[i]]) ||
          (m_maxh[i] != 0 && m_held[i] >= m_maxh[i] && others)) begin
        m_owner[i] = -1; m_gap[i] = GAPN;
      end else begin
        m_held[i]++;
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
      if (m_gap[i] == 0) model_arb(i, r);
    end else begin
      model_arb(i, r);
    end
  endtask

  task automatic push_exp(input int i);
    if (i == 0) exp_q0.push_back(model_out(0));
    else        exp_q1.push_back(model_out(1));
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual {gnt_a,gnt_c,gnt_t,sel,mute}=%b expected=%b",
               name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; sample 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q0.size() > 0) check("max16", actual(0), exp_q0.pop_front());
    if (exp_q1.size() > 0) check("max0", actual(1), exp_q1.pop_front());
  end

  task automatic cyc(input logic [2:0] r, input logic rv);
    @(negedge clk);
    rst = rv;
    {req_alexa, req_cpu, req_tv} = r;
    for (int i = 0; i < 2; i++) begin
      if (rv) model_reset(i); else model_step(i, r);
      push_exp(i);
    end
  endtask

  task automatic run(input logic [2:0] r, input int n);
    repeat (n) cyc(r, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic mid_reset(input logic [2:0] r_during);
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) model_reset(i);
    if (exp_q0.size() > 0) void'(exp_q0.pop_back());
    if (exp_q1.size() > 0) void'(exp_q1.pop_back());
    exp_q0.push_back(model_out(0));
    exp_q1.push_back(model_out(1));
    #1;
    check("async_rst_max16", actual(0), 6'b000_00_1);
    check("async_rst_max0", actual(1), 6'b000_00_1);
    cyc(r_during, 1'b1);
    cyc(r_during, 1'b1);
  endtask

  initial begin
    logic [2:0] r;
    for (int i = 0; i < 2; i++) model_reset(i);
    #1 rst = 1'b1;
    #1;
    check("reset_max16", actual(0), 6'b000_00_1);
    check("reset_max0", actual(1), 6'b000_00_1);
    cyc(3'b000, 1'b1);
    cyc(3'b000, 1'b1);

    // tv alone for 10 cycles, then released into gap and idle
    run(3'b001, 10);
    run(3'b000, 6);
    // cpu single-cycle pulse: held for the minimum only
    run(3'b010, 1);
    run(3'b000, 8);

    // all three from reset: round-robin with preemption on the MAX_HOLD=16 instance
    mid_reset(3'b111);
    run(3'b111, 60);
    run(3'b000, 8);

    // cpu held, alexa joins mid-hold; cpu preempted, then regains after alexa drops
    mid_reset(3'b000);
    run(3'b010, 5);
    run(3'b110, 30);
    run(3'b010, 10);
    run(3'b000, 8);

    // alexa granted, then async reset; tv wins first afterwards
    run(3'b100, 4);
    mid_reset(3'b011);
    run(3'b011, 10);
    run(3'b000, 8);

    // tv+cpu for 100 cycles: no preemption on the MAX_HOLD=0 instance
    mid_reset(3'b011);
    run(3'b011, 100);
    run(3'b000, 8);

    // randomized requests with some persistence
    r = 3'b000;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      cyc(r, 1'b0);
    end
    run(3'b000, 8);

    for (int w = 0; w < 4; w++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain remaining=%0d/%0d required=0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
